sync_corr_peak: RTL and testbench
=================================

SYNC_CORR_PEAK -- requirements
Module: sync_corr_peak

Interface
REQ-001 SHALL have parameter FBIT, default 7: fractional bits kept from each input sample (Q1.FBIT).
REQ-002 SHALL have parameter N_TAPS, default 64: correlator length, range 4..128.
REQ-003 SHALL have parameter D, default 64: lag of the delay-and-add pre-combiner, range 1..256.
REQ-004 SHALL have parameter HOLD, default 80: peak-detector holdoff in accepted samples.
REQ-005 SHALL have parameter CNT_W, default 16: sample-counter width.
REQ-006 SHALL use local constants CW = clog2(N_TAPS) and ACC_W = FBIT+2+CW.
REQ-007 SHALL have ports as follows (reset rst, synchronous, active-high; clock clk):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  sample strobe
  in_dat  in  16  sample, Q1.15
  coef_we  in  1  coefficient write strobe
  coef_addr  in  CW  tap index
  coef_dat  in  2  coefficient code
  coef_err  out  1  one-cycle pulse, write rejected
  thresh  in  ACC_W  peak threshold, static while streaming
  corr_valid  out  1  corr_out strobe
  corr_out  out  ACC_W  correlation metric, Q(CW+2).FBIT
  peak_valid  out  1  one-cycle peak report
  peak_val  out  ACC_W  peak metric
  peak_idx  out  CNT_W  sample index of the peak

Function
REQ-008 SHALL register in_dat[15:15-FBIT] on each in_valid cycle; this register SHALL be stage 1.
REQ-009 SHALL form fir_in = x + x delayed by D accepted samples, FBIT+2 bits wide and unsigned; the delay line SHALL advance only on accepted samples.
REQ-010 SHALL map coefficient codes per tap as follows: 00 gives 0; 01 gives fir_in>>1; 10 gives fir_in; 11 gives 0 (reserved).
REQ-011 SHALL implement a transposed adder chain: tap k output plus the registered partial sum of tap k-1, with registers enabled by the stage-1 valid.
REQ-012 SHALL use full width with no truncation or wrap at any stage; the final sum SHALL be ACC_W bits.
REQ-013 SHALL register corr_out when stage-1 valid is high, with corr_valid high in that same cycle. A sample accepted in cycle t SHALL produce corr_valid in cycle t+2. Gaps in in_valid SHALL stall the pipeline without loss.
REQ-014 SHALL write a coefficient on coef_we in the next cycle when in_valid is low in the coef_we cycle.
REQ-015 SHALL ignore a coef_we that occurs together with in_valid high, and SHALL pulse coef_err in the next cycle.
REQ-016 SHALL increment the sample counter on each corr_valid, wrapping from 2^CNT_W-1 to 0; the counter value tagged to a corr_out SHALL be the count before the increment.
REQ-017 SHALL implement a peak FSM with states IDLE, TRACK and HOLDOFF, advancing only on corr_valid cycles.
REQ-018 In IDLE, corr_out >= thresh SHALL move the FSM to TRACK and latch max = corr_out and idx = its counter value.
REQ-019 In TRACK, corr_out > max SHALL update max and idx; ties SHALL keep the earlier index.
REQ-020 In TRACK, corr_out < thresh SHALL pulse peak_valid with peak_val = max and peak_idx = idx, load the holdoff counter with HOLD, and move the FSM to HOLDOFF.
REQ-021 In HOLDOFF, the FSM SHALL decrement the holdoff counter per corr_valid and return to IDLE at 0; above-threshold samples in HOLDOFF SHALL be ignored.
REQ-022 SHALL hold peak_val and peak_idx until the next report.

Reset
REQ-023 On rst, corr_out, corr_valid, peak_valid, peak_val, peak_idx, coef_err, the partial sums, the delay line, the input register, the sample counter and the holdoff counter SHALL clear to 0.
REQ-024 On rst, the FSM SHALL go to IDLE.
REQ-025 Coefficient registers SHALL NOT be reset; their power-up value SHALL be 0.
REQ-026 rst asserted mid-TRACK SHALL abort the track with no peak_valid.

Structure
REQ-027 A shared package SHALL hold the coefficient code constants (COEF_ZERO, COEF_HALF, COEF_FULL), the FSM state enum, and the clog2 function.
REQ-028 There SHALL be one sub-module, corr_tap: code select plus partial-sum register, instantiated N_TAPS times through generate.

Verification
REQ-029 Config: N_TAPS=8, D=8, FBIT=7. All coefficients 10, single sample 0x4000 then zeros → corr_out = 64 for 16 consecutive corr_valid, then 0.
REQ-030 All coefficients 01, constant 0x7FFF input for 40 samples → corr_out settles at 8*(254>>1) = 1016.
REQ-031 Config: N_TAPS=8. coef_we together with in_valid → coef_err pulse, coefficients unchanged, output unaffected.
REQ-032 thresh = 100; metric sequence 50, 120, 200, 200, 90 → one peak_valid with peak_val = 200 and peak_idx at the first 200; no report during the next HOLD samples.
REQ-033 rst asserted mid-TRACK → no peak_valid, all outputs 0 in the next cycle, coefficients retained.
REQ-034 in_valid toggled every other cycle versus continuous in_valid with the same data → identical corr_out sequence.

Source files
------------

// File: rtl/sync_corr_peak_pkg.sv
// Shared constants, peak-detector state type and width helper for the
// sync_corr_peak correlator.
package sync_corr_peak_pkg;

    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_HALF = 2'b01;
    localparam logic [1:0] COEF_FULL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_HOLDOFF = 2'd2
    } peak_state_t;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_corr_peak_tap.sv
// One correlator tap: coefficient code select feeding a transposed-chain
// partial-sum register.
module corr_tap
    import sync_corr_peak_pkg::*;
#(
    parameter int FIN_W = 9,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             coef_we,
    input  logic [1:0]       coef_dat,
    input  logic [FIN_W-1:0] fir_in,
    input  logic [ACC_W-1:0] p_in,
    output logic [ACC_W-1:0] p_q
);

    // The code survives rst so a programmed pattern outlives a pipeline flush.
    logic [1:0]       code = COEF_ZERO;
    logic [ACC_W-1:0] tap_val;

    always_ff @(posedge clk) begin
        if (coef_we) code <= coef_dat;
    end

    always_comb begin
        tap_val = '0;
        case (code)
            COEF_HALF: tap_val = ACC_W'(fir_in >> 1);
            COEF_FULL: tap_val = ACC_W'(fir_in);
            default:   tap_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)     p_q <= '0;
        else if (en) p_q <= p_in + tap_val;
    end

endmodule

// File: rtl/sync_corr_peak.sv
// Delay-and-add pre-combiner, transposed ternary-coefficient correlator and
// threshold/holdoff peak detector for sync-word detection.
module sync_corr_peak
    import sync_corr_peak_pkg::*;
#(
    parameter int  FBIT   = 7,
    parameter int  N_TAPS = 64,
    parameter int  D      = 64,
    parameter int  HOLD   = 80,
    parameter int  CNT_W  = 16,
    localparam int CW     = clog2(N_TAPS),
    localparam int ACC_W  = FBIT + 2 + CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_dat,
    input  logic             coef_we,
    input  logic [CW-1:0]    coef_addr,
    input  logic [1:0]       coef_dat,
    output logic             coef_err,
    input  logic [ACC_W-1:0] thresh,
    output logic             corr_valid,
    output logic [ACC_W-1:0] corr_out,
    output logic             peak_valid,
    output logic [ACC_W-1:0] peak_val,
    output logic [CNT_W-1:0] peak_idx
);

    localparam int XW    = FBIT + 1;
    localparam int FIN_W = FBIT + 2;
    localparam int HW    = clog2(HOLD + 1);

    logic [XW-1:0]    x_q;
    logic             v1_q;
    logic [XW-1:0]    dly_q [D];
    logic [FIN_W-1:0] fir_in;
    logic [ACC_W-1:0] psum [N_TAPS];
    logic             coef_wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            v1_q       <= 1'b0;
            corr_valid <= 1'b0;
            coef_err   <= 1'b0;
            for (int i = 0; i < D; i++) dly_q[i] <= '0;
        end else begin
            v1_q       <= in_valid;
            corr_valid <= v1_q;
            coef_err   <= coef_we & in_valid;
            if (in_valid) begin
                x_q      <= in_dat[15 -: XW];
                dly_q[0] <= x_q;
                for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // x_q and dly_q[D-1] are D accepted samples apart whenever v1_q is high.
    assign fir_in     = FIN_W'(x_q) + FIN_W'(dly_q[D-1]);
    assign coef_wr_ok = coef_we & ~in_valid;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        logic [ACC_W-1:0] p_prev;
        if (k == 0) begin : g_first
            assign p_prev = '0;
        end else begin : g_chain
            assign p_prev = psum[k-1];
        end
        corr_tap #(.FIN_W(FIN_W), .ACC_W(ACC_W)) u_tap (
            .clk      (clk),
            .rst      (rst),
            .en       (v1_q),
            .coef_we  (coef_wr_ok && (coef_addr == CW'(k))),
            .coef_dat (coef_dat),
            .fir_in   (fir_in),
            .p_in     (p_prev),
            .p_q      (psum[k])
        );
    end

    // The last partial-sum register is the correlator output register.
    assign corr_out = psum[N_TAPS-1];

    peak_state_t      state_q, state_d;
    logic [ACC_W-1:0] max_q, max_d, peak_val_d;
    logic [CNT_W-1:0] idx_q, idx_d, cnt_q, peak_idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             peak_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            max_q      <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            peak_valid <= 1'b0;
            peak_val   <= '0;
            peak_idx   <= '0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            peak_valid <= peak_valid_d;
            peak_val   <= peak_val_d;
            peak_idx   <= peak_idx_d;
            if (corr_valid) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        peak_valid_d = 1'b0;
        peak_val_d   = peak_val;
        peak_idx_d   = peak_idx;
        if (corr_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (corr_out >= thresh) begin
                        state_d = ST_TRACK;
                        max_d   = corr_out;
                        idx_d   = cnt_q;
                    end
                end
                ST_TRACK: begin
                    if (corr_out < thresh) begin
                        peak_valid_d = 1'b1;
                        peak_val_d   = max_q;
                        peak_idx_d   = idx_q;
                        hold_d       = HW'(HOLD);
                        state_d      = ST_HOLDOFF;
                    end else if (corr_out > max_q) begin
                        max_d = corr_out;
                        idx_d = cnt_q;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q <= HW'(1)) begin
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_corr_peak.sv
// Directed and randomized bench for sync_corr_peak against a sample-history
// reference model with an expected queue and a peak-rule model.
module tb_sync_corr_peak;

    localparam int FBIT   = 7;
    localparam int N_TAPS = 8;
    localparam int D      = 8;
    localparam int HOLD   = 12;
    localparam int CNT_W  = 6;
    localparam int CW     = 3;
    localparam int ACC_W  = FBIT + 2 + CW;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [15:0]      in_dat;
    logic             coef_we;
    logic [CW-1:0]    coef_addr;
    logic [1:0]       coef_dat;
    logic             coef_err;
    logic [ACC_W-1:0] thresh;
    logic             corr_valid;
    logic [ACC_W-1:0] corr_out;
    logic             peak_valid;
    logic [ACC_W-1:0] peak_val;
    logic [CNT_W-1:0] peak_idx;

    sync_corr_peak #(
        .FBIT(FBIT), .N_TAPS(N_TAPS), .D(D), .HOLD(HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_dat     (in_dat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_dat   (coef_dat),
        .coef_err   (coef_err),
        .thresh     (thresh),
        .corr_valid (corr_valid),
        .corr_out   (corr_out),
        .peak_valid (peak_valid),
        .peak_val   (peak_val),
        .peak_idx   (peak_idx)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int               checks = 0;
    int               errors = 0;
    int               hist[$];
    logic [ACC_W-1:0] exp_q[$];
    int               acc_q[$];
    int               err_q[$];
    int               coef_m[N_TAPS];
    int               thr;
    int               cnt_m, pst, pmax, pidx, phold;
    logic             pend;
    int               pend_val, pend_idx;
    int               n64, npk, last_obs;
    logic [ACC_W-1:0] e_v;
    int               ac_v;
    logic             exp_err;
    logic [15:0]      data_a[30];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference: output for the newest sample is the coefficient-weighted sum
    // of the last N_TAPS pre-combined values, tap N_TAPS-1 on the newest.
    function automatic int model_corr();
        int n, s, m, f;
        n = hist.size() - 1;
        s = 0;
        for (int k = 0; k < N_TAPS; k++) begin
            m = n - (N_TAPS - 1 - k);
            if (m >= 0) begin
                f = hist[m] + ((m >= D) ? hist[m-D] : 0);
                if (coef_m[k] == 1)      s += f / 2;
                else if (coef_m[k] == 2) s += f;
            end
        end
        return s;
    endfunction

    function automatic void peak_model(input int e);
        int idx;
        idx   = cnt_m;
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
        if (pst == 0) begin
            if (e >= thr) begin pst = 1; pmax = e; pidx = idx; end
        end else if (pst == 1) begin
            if (e < thr) begin
                pend = 1'b1; pend_val = pmax; pend_idx = pidx;
                phold = HOLD; pst = 2;
            end else if (e > pmax) begin
                pmax = e; pidx = idx;
            end
        end else begin
            phold--;
            if (phold <= 0) pst = 0;
        end
    endfunction

    // driver tasks
    task automatic step(input logic iv, input logic [15:0] d, input logic we,
                        input int addr, input logic [1:0] cd);
        logic [FBIT:0] xs;
        @(posedge clk); #1;
        in_valid  = iv;
        in_dat    = d;
        coef_we   = we;
        coef_addr = addr[CW-1:0];
        coef_dat  = cd;
        if (iv) begin
            xs = d[15 -: FBIT+1];
            hist.push_back(int'(xs));
            exp_q.push_back(ACC_W'(model_corr()));
            acc_q.push_back(cyc);
        end
        if (we && !iv) coef_m[addr] = int'(cd);
        if (we && iv)  err_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 0, 2'b00);
    endtask

    task automatic send(input logic [15:0] d);
        step(1'b1, d, 1'b0, 0, 2'b00);
    endtask

    task automatic set_thr(input int v);
        thr    = v;
        thresh = v[ACC_W-1:0];
    endtask

    task automatic load_coefs(input int c[N_TAPS]);
        for (int k = 0; k < N_TAPS; k++) step(1'b0, 16'h0, 1'b1, k, c[k][1:0]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        hist.delete(); exp_q.delete(); acc_q.delete(); err_q.delete();
        cnt_m = 0; pst = 0; pend = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        idle(3);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // monitor: compares at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (peak_valid || pend) begin
                chk("peak_valid", peak_valid, pend);
                if (pend && peak_valid) begin
                    chk("peak_val", peak_val, pend_val);
                    chk("peak_idx", peak_idx, pend_idx);
                end
            end
            if (peak_valid) npk++;
            pend = 1'b0;
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            if (coef_err || exp_err) chk("coef_err", coef_err, exp_err);
            if (corr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("corr_spurious", corr_valid, 1'b0);
                end else begin
                    e_v  = exp_q.pop_front();
                    ac_v = acc_q.pop_front();
                    chk("corr_out", corr_out, e_v);
                    chk("corr_latency", cyc, ac_v + 2);
                    last_obs = int'(corr_out);
                    if (corr_out == 64) n64++;
                    peak_model(int'(e_v));
                end
            end
            if (acc_q.size() > 0 && cyc > acc_q[0] + 2) begin
                chk("corr_missing_at", cyc, acc_q[0] + 2);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
    end

    int c_tab[N_TAPS];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dat = '0;
        coef_we = 1'b0; coef_addr = '0; coef_dat = '0;
        pend = 1'b0; cnt_m = 0; pst = 0; n64 = 0; npk = 0; last_obs = 0;
        for (int k = 0; k < N_TAPS; k++) coef_m[k] = 0;
        set_thr(4095);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_corr_out", corr_out, 0);
        chk("rst_corr_valid", corr_valid, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_val", peak_val, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_coef_err", coef_err, 0);

        // power-up coefficients are zero
        for (int i = 0; i < 12; i++) send(16'($urandom));
        drain();

        // impulse through all-FULL taps
        for (int k = 0; k < N_TAPS; k++) c_tab[k] = 2;
        load_coefs(c_tab);
        do_reset();
        n64 = 0;
        send(16'h4000);
        for (int i = 0; i < 23; i++) send(16'h0000);
        drain();
        chk("impulse_run_len", n64, 16);
        chk("impulse_tail", last_obs, 0);

        // constant full-scale input through all-HALF taps
        for (int k = 0; k < N_TAPS; k++) c_tab[k] = 1;
        load_coefs(c_tab);
        do_reset();
        for (int i = 0; i < 40; i++) send(16'h7FFF);
        drain();
        chk("settle_1016", last_obs, 1016);

        // coefficient writes colliding with samples are rejected
        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 2) step(1'b1, 16'($urandom), 1'b1, $urandom_range(0, N_TAPS-1), 2'b10);
            else            send(16'($urandom));
        end
        drain();

        // peak detection: only the newest-sample tap active
        for (int k = 0; k < N_TAPS; k++) c_tab[k] = (k == N_TAPS-1) ? 2 : 0;
        load_coefs(c_tab);
        set_thr(100);
        do_reset();
        npk = 0;
        send({8'd50, 8'h00});
        send({8'd120, 8'h00});
        send({8'd200, 8'h00});
        send({8'd200, 8'h00});
        send({8'd90, 8'h00});
        for (int i = 0; i < 30; i++) send(16'h0000);
        drain();
        chk("peak_count", npk, 1);
        chk("peak_val_held", peak_val, 200);
        chk("peak_idx_first", peak_idx, 2);

        // reset while tracking aborts the report
        for (int i = 0; i < 10; i++) send({8'd150, 8'h00});
        do_reset();
        @(negedge clk);
        chk("abort_corr_out", corr_out, 0);
        chk("abort_corr_valid", corr_valid, 0);
        chk("abort_peak_valid", peak_valid, 0);
        chk("abort_peak_val", peak_val, 0);
        chk("abort_peak_idx", peak_idx, 0);
        for (int i = 0; i < 20; i++) send(16'($urandom_range(0, 16'hFFFF)));
        drain();

        // same data, continuous versus every-other-cycle strobes
        for (int k = 0; k < N_TAPS; k++) c_tab[k] = $urandom_range(0, 3);
        load_coefs(c_tab);
        set_thr($urandom_range(300, 1500));
        for (int i = 0; i < 30; i++) data_a[i] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 30; i++) send(data_a[i]);
        drain();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send(data_a[i]);
            idle(1);
        end
        drain();

        // long random stream with random gaps, counter wraps
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(16'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
